// File: rtl/gray_pkg.sv
// Shared definitions for the Gray sweep controller: FSM state encodings,
// default field widths and the 3-bit Gray next-code functions.
package gray_pkg;

  localparam int STEP_W_DEF  = 4;
  localparam int DWELL_W_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_STEP  = 2'd1;
  localparam state_t ST_DWELL = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Forward Gray order: 000,001,011,010,110,111,101,100, then back to 000
  function automatic logic [2:0] gray_up(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b000:  nxt = 3'b001;
      3'b001:  nxt = 3'b011;
      3'b011:  nxt = 3'b010;
      3'b010:  nxt = 3'b110;
      3'b110:  nxt = 3'b111;
      3'b111:  nxt = 3'b101;
      3'b101:  nxt = 3'b100;
      3'b100:  nxt = 3'b000;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  // Reverse Gray order, the exact inverse of gray_up
  function automatic logic [2:0] gray_down(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b000:  nxt = 3'b100;
      3'b100:  nxt = 3'b101;
      3'b101:  nxt = 3'b111;
      3'b111:  nxt = 3'b110;
      3'b110:  nxt = 3'b010;
      3'b010:  nxt = 3'b011;
      3'b011:  nxt = 3'b001;
      3'b001:  nxt = 3'b000;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gray_sweep_ctrl_if.sv
// Command/status bundle between upstream logic and the Gray sweep controller.
interface gray_sweep_ctrl_if
  import gray_pkg::*;
#(
  parameter int STEP_W  = STEP_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);
  logic               start;
  logic               dir;
  logic [STEP_W-1:0]  steps;
  logic [DWELL_W-1:0] dwell;
  logic               abort;
  logic [2:0]         y;
  logic               busy;
  logic               done;
  logic               aborted;

  modport master (
    output start, dir, steps, dwell, abort,
    input  y, busy, done, aborted
  );

  modport slave (
    input  start, dir, steps, dwell, abort,
    output y, busy, done, aborted
  );
endinterface

// File: rtl/gray3_updown.sv
// 3-bit Gray up/down counter; advances one code per enabled cycle.
module gray3_updown
  import gray_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  output logic [2:0] y
);

  logic [2:0] y_q;
  logic [2:0] y_d;

  // Select the neighbouring code in the requested direction, or hold
  always_comb begin
    y_d = y_q;
    if (en) begin
      if (dir) begin
        y_d = gray_up(y_q);
      end else begin
        y_d = gray_down(y_q);
      end
    end else begin
      y_d = y_q;
    end
  end

  // Code register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 3'b000;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Sweep sequencer: runs a commanded number of Gray counter steps in one
// direction with optional dwell cycles between steps, with abort support.
module gray_sweep_ctrl
  import gray_pkg::*;
#(
  parameter int STEP_W  = STEP_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
)(
  input  logic               clk,
  input  logic               rst,
  gray_sweep_ctrl_if.slave   bus
);

  localparam logic [STEP_W-1:0]  STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0]  STEP_ZERO  = {STEP_W{1'b0}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};

  state_t             state_q,     state_d;
  logic               dir_q,       dir_d;
  logic [STEP_W-1:0]  remaining_q, remaining_d;
  logic [DWELL_W-1:0] dwell_q,     dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  // zero_q marks a zero-length command so its DONE cycle does not raise busy
  logic               zero_q,      zero_d;
  logic               abrt_q,      abrt_d;
  logic               en_s;
  logic [2:0]         y_s;

  // Next-state and datapath decisions for the sweep sequencer
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    zero_d      = zero_q;
    abrt_d      = abrt_q;
    case (state_q)
      ST_IDLE: begin
        abrt_d = 1'b0;
        if (bus.start) begin
          dir_d       = bus.dir;
          remaining_d = bus.steps;
          dwell_d     = bus.dwell;
          if (bus.steps == STEP_ZERO) begin
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = ST_STEP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        // The step issued this cycle always completes, even under abort
        remaining_d = remaining_q - STEP_ONE;
        if (bus.abort) begin
          abrt_d  = 1'b1;
          state_d = ST_DONE;
        end else if (remaining_q == STEP_ONE) begin
          state_d = ST_DONE;
        end else if (dwell_q == DWELL_ZERO) begin
          state_d = ST_STEP;
        end else begin
          dwell_cnt_d = dwell_q - DWELL_ONE;
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (bus.abort) begin
          abrt_d  = 1'b1;
          state_d = ST_DONE;
        end else if (dwell_cnt_q == DWELL_ZERO) begin
          state_d = ST_STEP;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
        end
      end
      ST_DONE: begin
        abrt_d  = 1'b0;
        zero_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      remaining_q <= STEP_ZERO;
      dwell_q     <= DWELL_ZERO;
      dwell_cnt_q <= DWELL_ZERO;
      zero_q      <= 1'b0;
      abrt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      zero_q      <= zero_d;
      abrt_q      <= abrt_d;
    end
  end

  assign en_s = (state_q == ST_STEP);

  gray3_updown u_gray (
    .clk (clk),
    .rst (rst),
    .en  (en_s),
    .dir (dir_q),
    .y   (y_s)
  );

  assign bus.y       = y_s;
  assign bus.done    = (state_q == ST_DONE);
  assign bus.aborted = (state_q == ST_DONE) && abrt_q;
  assign bus.busy    = (state_q == ST_STEP) || (state_q == ST_DWELL) ||
                       ((state_q == ST_DONE) && !zero_q);

endmodule
